instr_fetch_ctrl: RTL and testbench

- Sequences the byte-wide instruction memory (8-bit words, loaded from ins.mem) to fetch 32-bit RISC-V instructions.
- Each instruction is assembled little-endian from 4 consecutive byte reads.
- Presents the instruction, its PC and its opcode to decode over a valid/ready handshake.
- Owns the PC: sequential +4 increment and branch/jump redirect with flush of any partial fetch.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/instr_fetch_ctrl_if.sv | 57 +++++
 rtl/fetch_byte_asm.sv | 33 +++
 rtl/instr_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: fetch FSM states, instruction size and
// base opcode encodings used by the fetch controller and decode.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LAST  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Major opcode field of a 32-bit instruction.
    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle of the instruction fetch controller: byte memory read port,
// redirect request and the valid/ready instruction output to decode.
// Optional macro FETCH_ILLEGAL_CHECK_EN adds the illegal flag.
interface instr_fetch_ctrl_if #(
    parameter int AW = 8
);
    logic          fetch_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic [6:0]    out_opcode;
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic          illegal;
`endif

    // Fetch controller side
    modport master (
`ifdef FETCH_ILLEGAL_CHECK_EN
        output illegal,
`endif
        input  fetch_en,
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_opcode
    );

    // Memory / decode / branch-unit side
    modport slave (
`ifdef FETCH_ILLEGAL_CHECK_EN
        input  illegal,
`endif
        output fetch_en,
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_opcode
    );
endinterface

// File: rtl/fetch_byte_asm.sv
// Little-endian instruction assembly register: one byte lane per
// instruction byte, written by index, cleared by reset or flush.
module fetch_byte_asm
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap_en,
    input  logic [1:0]  cap_idx,
    input  logic [7:0]  cap_data,
    output logic [31:0] word
);

    genvar gi;
    generate
        for (gi = 0; gi < INSTR_BYTES; gi++) begin : g_lane
            logic [7:0] byte_reg;

            // Capture this lane when its byte index is addressed; flush wins
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    byte_reg <= 8'h00;
                end else if (cap_en && (cap_idx == 2'(gi))) begin
                    byte_reg <= cap_data;
                end
            end

            assign word[gi*8 +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks the byte-wide instruction memory four
// reads per instruction, assembles the word and hands it to decode over
// valid/ready. Owns the PC (+4 on consume, redirect with flush).
// Optional macro FETCH_ILLEGAL_CHECK_EN: flags instructions whose low two
// bits are not 2'b11 and halts fetching after they are consumed until a
// redirect or reset.
module instr_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
)(
    input  logic               clk,
    input  logic               rst,
    instr_fetch_ctrl_if.master bus
);

    fetch_state_e  state_reg;
    fetch_state_e  state_next;
    logic [1:0]    k_reg;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] out_pc_reg;
    logic [31:0]   asm_word;
    logic          cap_en;
    logic [1:0]    cap_idx;
    logic          handshake;
    logic          fetch_ok;
    logic          unused_bits;

    // Low target bits are forced to zero, so they are deliberately dropped.
    assign unused_bits = ^bus.redirect_pc[1:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic illegal_reg;

    // Sticky illegal flag, set as the instruction enters HOLD
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_LAST && asm_word[1:0] != 2'b11) begin
            illegal_reg <= 1'b1;
        end
    end

    assign fetch_ok    = ~illegal_reg;
    assign bus.illegal = illegal_reg;
`else
    assign fetch_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a redirect overrides every state
    always_comb begin
        state_next = state_reg;
        if (bus.redirect_valid) begin
            state_next = bus.fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (bus.fetch_en && fetch_ok) state_next = ST_FETCH;
                ST_FETCH: if (k_reg == 2'd3) state_next = ST_LAST;
                ST_LAST:  state_next = ST_HOLD;
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_next = (bus.fetch_en && fetch_ok) ? ST_FETCH : ST_IDLE;
                    end
                end
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs and byte-capture controls
    always_comb begin
        bus.mem_rd_en = (state_reg == ST_FETCH);
        bus.mem_addr  = pc_reg + AW'(k_reg);
        bus.out_valid = (state_reg == ST_HOLD);
        handshake     = (state_reg == ST_HOLD) && bus.out_ready;
        cap_en        = 1'b0;
        cap_idx       = 2'd0;
        if (!bus.redirect_valid) begin
            if (state_reg == ST_FETCH && k_reg != 2'd0) begin
                cap_en  = 1'b1;
                cap_idx = k_reg - 2'd1;
            end else if (state_reg == ST_LAST) begin
                cap_en  = 1'b1;
                cap_idx = 2'd3;
            end
        end
    end

    // PC, byte counter and registered output PC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            k_reg      <= 2'd0;
            out_pc_reg <= '0;
        end else if (bus.redirect_valid) begin
            pc_reg <= {bus.redirect_pc[AW-1:2], 2'b00};
            k_reg  <= 2'd0;
        end else begin
            k_reg <= (state_reg == ST_FETCH) ? k_reg + 2'd1 : 2'd0;
            if (state_reg == ST_LAST) begin
                out_pc_reg <= pc_reg;
            end
            if (handshake) begin
                pc_reg <= pc_reg + AW'(INSTR_BYTES);
            end
        end
    end

    fetch_byte_asm u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.redirect_valid),
        .cap_en   (cap_en),
        .cap_idx  (cap_idx),
        .cap_data (bus.mem_rdata),
        .word     (asm_word)
    );

    assign bus.out_instr  = asm_word;
    assign bus.out_pc     = out_pc_reg;
    assign bus.out_opcode = opcode_of(asm_word);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: stimulus pushes expected
// instructions, monitors pop and compare on every output handshake and log
// every memory read address.
module tb_instr_fetch_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic [6:0]  opc;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;

    instr_fetch_ctrl_if #(.AW(8)) bus_a ();
    instr_fetch_ctrl_if #(.AW(8)) bus_b ();

    instr_fetch_ctrl #(.AW(8), .RESET_PC(8'h00)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    instr_fetch_ctrl #(.AW(8), .RESET_PC(8'hFC)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    exp_t       exp_q_a [$];
    exp_t       exp_q_b [$];
    logic [7:0] rd_log_a [$];
    logic [7:0] rd_log_b [$];
    logic [7:0] exp_rd [$];
    int tests_run    = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memories: data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_rd_en) bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        tests_run++;
        if (act !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input bit b, input logic [31:0] instr, input logic [7:0] pc,
                            input logic [6:0] opc, input logic ill);
        exp_t e;
        e.instr = instr; e.pc = pc; e.opc = opc; e.ill = ill;
        if (b) exp_q_b.push_back(e);
        else   exp_q_a.push_back(e);
    endtask

    // Advance until out_valid is seen; returns cycles taken, fails on timeout
    task automatic wait_valid(input bit b, input string name, output int n);
        logic v;
        n = 0;
        do begin
            tick();
            n++;
            v = b ? bus_b.out_valid : bus_a.out_valid;
        end while (v !== 1'b1 && n < 40);
        tests_run++;
        if (v !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: out_valid not seen after %0d cycles, want it within 40", name, n);
        end
    endtask

    task automatic check_rd(input bit b, input string name);
        logic [7:0] got [$];
        if (b) got = rd_log_b;
        else   got = rd_log_a;
        chk($sformatf("%s_count", name), 64'(got.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < got.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), got[i], exp_rd[i]);
        end
        $display("[TB] %s: %0d reads checked", name, got.size());
    endtask

    // Monitor A: compare each consumed instruction against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.mem_rd_en === 1'b1) rd_log_a.push_back(bus_a.mem_addr);
            if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
                if (exp_q_a.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL a_unexpected: got pc %0h, want no transaction", bus_a.out_pc);
                end else begin
                    e = exp_q_a.pop_front();
                    chk("a_instr", bus_a.out_instr, e.instr);
                    chk("a_pc", bus_a.out_pc, e.pc);
                    chk("a_opcode", bus_a.out_opcode, e.opc);
`ifdef FETCH_ILLEGAL_CHECK_EN
                    chk("a_illegal", bus_a.illegal, e.ill);
`endif
                    $display("[TB] A out pc=%02h instr=%08h opc=%07b", bus_a.out_pc,
                             bus_a.out_instr, bus_a.out_opcode);
                end
            end
        end
    end

    // Monitor B: same for the RESET_PC = FC instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_b.mem_rd_en === 1'b1) rd_log_b.push_back(bus_b.mem_addr);
            if (bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
                if (exp_q_b.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b_unexpected: got pc %0h, want no transaction", bus_b.out_pc);
                end else begin
                    e = exp_q_b.pop_front();
                    chk("b_instr", bus_b.out_instr, e.instr);
                    chk("b_pc", bus_b.out_pc, e.pc);
                    chk("b_opcode", bus_b.out_opcode, e.opc);
                    $display("[TB] B out pc=%02h instr=%08h opc=%07b", bus_b.out_pc,
                             bus_b.out_instr, bus_b.out_opcode);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        {mem_a[8'h00], mem_a[8'h01], mem_a[8'h02], mem_a[8'h03]} = {8'h13, 8'h05, 8'hA0, 8'h00};
        {mem_a[8'h04], mem_a[8'h05], mem_a[8'h06], mem_a[8'h07]} = {8'hB7, 8'h12, 8'h34, 8'h00};
        {mem_a[8'h08], mem_a[8'h09], mem_a[8'h0A], mem_a[8'h0B]} = {8'h6F, 8'h00, 8'h40, 8'h00};
        {mem_a[8'h20], mem_a[8'h21], mem_a[8'h22], mem_a[8'h23]} = {8'h67, 8'h80, 8'h00, 8'h00};
        {mem_a[8'h40], mem_a[8'h41], mem_a[8'h42], mem_a[8'h43]} = {8'h23, 8'h20, 8'h11, 8'h00};
        mem_a[8'h60] = 8'h01;
        {mem_b[8'hFC], mem_b[8'hFD], mem_b[8'hFE], mem_b[8'hFF]} = {8'h93, 8'h00, 8'h10, 8'h00};
        {mem_b[8'h00], mem_b[8'h01], mem_b[8'h02], mem_b[8'h03]} = {8'h33, 8'h01, 8'h31, 8'h00};

        rst = 1'b1;
        bus_a.fetch_en = 1'b0; bus_a.out_ready = 1'b0;
        bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 8'h00;
        bus_b.fetch_en = 1'b0; bus_b.out_ready = 1'b1;
        bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_mem_rd_en", bus_a.mem_rd_en, 1'b0);
        chk("rst_out_instr", bus_a.out_instr, 32'h0);
        chk("rst_out_pc", bus_a.out_pc, 8'h00);
        chk("rst_out_opcode", bus_a.out_opcode, 7'h00);
        chk("rst_b_out_pc", bus_b.out_pc, 8'h00);
`ifdef FETCH_ILLEGAL_CHECK_EN
        chk("rst_illegal", bus_a.illegal, 1'b0);
`endif

        // First fetch from 0: latency and the following sequential fetch at 4
        rst = 1'b0;
        rd_log_a.delete();
        bus_a.fetch_en = 1'b1; bus_a.out_ready = 1'b1;
        push_exp(1'b0, 32'h00A00513, 8'h00, 7'b0010011, 1'b0);
        wait_valid(1'b0, "first_valid", n);
        chk("first_latency", 64'(n), 64'd6);
        tick();
        bus_a.fetch_en = 1'b0; bus_a.out_ready = 1'b0;
        push_exp(1'b0, 32'h003412B7, 8'h04, 7'b0110111, 1'b0);
        wait_valid(1'b0, "second_valid", n);
        exp_rd = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        check_rd(1'b0, "seq_reads");

        // Decode stalls in HOLD: outputs stable, no reads
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_stable%0d", i),
                {bus_a.out_valid, bus_a.mem_rd_en, bus_a.out_instr, bus_a.out_pc},
                {1'b1, 1'b0, 32'h003412B7, 8'h04});
            tick();
        end
        bus_a.out_ready = 1'b1;
        tick();
        chk("after_hs_valid", bus_a.out_valid, 1'b0);

        // Redirect to 0x23 while fetch is at k = 2 (pc 8)
        rd_log_a.delete();
        bus_a.fetch_en = 1'b1;
        tick(); tick(); tick();
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h23;
        tick();
        bus_a.redirect_valid = 1'b0; bus_a.fetch_en = 1'b0;
        chk("redir_valid_low", bus_a.out_valid, 1'b0);
        chk("redir_first_addr", bus_a.mem_addr, 8'h20);
        push_exp(1'b0, 32'h00008067, 8'h20, 7'b1100111, 1'b0);
        wait_valid(1'b0, "redir_valid", n);
        tick();
        exp_rd = {8'h08, 8'h09, 8'h0A, 8'h20, 8'h21, 8'h22, 8'h23};
        check_rd(1'b0, "redir_reads");

        // Redirect to 0x40 in the same cycle as the handshake at pc 0
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h00; bus_a.fetch_en = 1'b1;
        tick();
        bus_a.redirect_valid = 1'b0;
        push_exp(1'b0, 32'h00A00513, 8'h00, 7'b0010011, 1'b0);
        wait_valid(1'b0, "pc0_valid", n);
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h40;
        tick();
        bus_a.redirect_valid = 1'b0; bus_a.fetch_en = 1'b0;
        chk("hs_redir_valid_low", bus_a.out_valid, 1'b0);
        chk("hs_redir_addr", bus_a.mem_addr, 8'h40);
        push_exp(1'b0, 32'h00112023, 8'h40, 7'b0100011, 1'b0);
        wait_valid(1'b0, "redir40_valid", n);
        tick();

`ifdef FETCH_ILLEGAL_CHECK_EN
        // Compressed/illegal encoding at 0x60 halts fetching until a redirect
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h60; bus_a.fetch_en = 1'b1;
        tick();
        bus_a.redirect_valid = 1'b0;
        push_exp(1'b0, 32'h00000001, 8'h60, 7'b0000001, 1'b1);
        wait_valid(1'b0, "ill_valid", n);
        chk("ill_flag", bus_a.illegal, 1'b1);
        tick();
        rd_log_a.delete();
        repeat (8) tick();
        exp_rd.delete();
        check_rd(1'b0, "ill_no_reads");
        chk("ill_sticky", bus_a.illegal, 1'b1);
        bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 8'h00;
        tick();
        bus_a.redirect_valid = 1'b0; bus_a.fetch_en = 1'b0;
        chk("ill_cleared", bus_a.illegal, 1'b0);
        push_exp(1'b0, 32'h00A00513, 8'h00, 7'b0010011, 1'b0);
        wait_valid(1'b0, "ill_resume_valid", n);
        tick();
`endif

        // Instance B: RESET_PC = FC wraps to 0
        rd_log_b.delete();
        bus_b.fetch_en = 1'b1;
        push_exp(1'b1, 32'h00100093, 8'hFC, 7'b0010011, 1'b0);
        push_exp(1'b1, 32'h00310133, 8'h00, 7'b0110011, 1'b0);
        wait_valid(1'b1, "wrap_valid1", n);
        tick();
        bus_b.fetch_en = 1'b0;
        wait_valid(1'b1, "wrap_valid2", n);
        tick();
        exp_rd = {8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        check_rd(1'b1, "wrap_reads");

        repeat (3) tick();
        chk("a_queue_drained", 64'(exp_q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
